// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: forwarding, load-use stall, branch/jump flush, STOP halt.
// Define FP_MULTICYCLE_EN to build the multicycle ADDF/MULTF occupancy stall (FP_BUSY).
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 3,
    parameter int FLUSH_DEPTH = 3,
    parameter int FP_LAT      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_jump_i,
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_fp_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_reg_write_i,
    input  logic              mem_branch_taken_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_reg_write_i,
    input  logic              stop_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              pc_stall_o,
    output logic              if_id_stall_o,
    output logic              id_ex_stall_o,
    output logic              back_stall_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              flush_ex_mem_o,
    output logic [1:0]        state_o
);

    // state   | meaning
    // RUN     | normal issue; load-use, jump, branch and FP start resolved here
    // FLUSH   | trailing IF/ID bubbles after a taken branch, counter down to 0
    // FP_BUSY | FP op occupies EX; front end held, EX/MEM fed bubbles
    // HALT    | STOP reached; whole pipe frozen until rst
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_FLUSH   = 2'd1;
    localparam logic [1:0] ST_HALT    = 2'd3;

    localparam int MAX_CNT = (FLUSH_DEPTH > FP_LAT) ? FLUSH_DEPTH : FP_LAT;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

`ifdef FP_MULTICYCLE_EN
    localparam logic [1:0]       ST_FP_BUSY = 2'd2;
    localparam logic [CNT_W-1:0] FP_LOAD    = CNT_W'((FP_LAT > 1) ? (FP_LAT - 2) : 0);
`else
    logic unused_fp;
    assign unused_fp = ex_fp_i;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] fwd_a, fwd_b;
    logic       load_use;
    logic       pc_stall, if_id_stall, id_ex_stall, back_stall;
    logic       flush_if_id, flush_id_ex, flush_ex_mem;

    // MEM result is younger than WB, so it wins when both match
    always_comb begin
        fwd_a = 2'b00;
        if (ex_rs_i != '0 && ex_rs_i == mem_rd_i && mem_reg_write_i) begin
            fwd_a = 2'b01;
        end else if (ex_rs_i != '0 && ex_rs_i == wb_rd_i && wb_reg_write_i) begin
            fwd_a = 2'b10;
        end
    end

    always_comb begin
        fwd_b = 2'b00;
        if (ex_rt_i != '0 && ex_rt_i == mem_rd_i && mem_reg_write_i) begin
            fwd_b = 2'b01;
        end else if (ex_rt_i != '0 && ex_rt_i == wb_rd_i && wb_reg_write_i) begin
            fwd_b = 2'b10;
        end
    end

    assign load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs_i) || (ex_rd_i == id_rt_i));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        back_stall   = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;

        if (state_q == ST_HALT || stop_i) begin
            state_d     = ST_HALT;
            cnt_d       = '0;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            back_stall  = 1'b1;
        end else if (mem_branch_taken_i && state_q != ST_FLUSH) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            cnt_d        = FLUSH_LOAD;
            state_d      = (FLUSH_DEPTH > 1) ? ST_FLUSH : ST_RUN;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    flush_if_id = 1'b1;
                    if (mem_branch_taken_i) begin
                        cnt_d = FLUSH_LOAD;
                    end else if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
`ifdef FP_MULTICYCLE_EN
                ST_FP_BUSY: begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    flush_ex_mem = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
`endif
                default: begin
`ifdef FP_MULTICYCLE_EN
                    if (ex_fp_i && FP_LAT > 1) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        flush_ex_mem = 1'b1;
                        cnt_d        = FP_LOAD;
                        state_d      = ST_FP_BUSY;
                    end else
`endif
                    if (load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (id_jump_i) begin
                        flush_if_id = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // rst masks everything combinationally, including a concurrent stop_i
    assign fwd_a_o        = rst ? 2'b00 : fwd_a;
    assign fwd_b_o        = rst ? 2'b00 : fwd_b;
    assign pc_stall_o     = pc_stall & ~rst;
    assign if_id_stall_o  = if_id_stall & ~rst;
    assign id_ex_stall_o  = id_ex_stall & ~rst;
    assign back_stall_o   = back_stall & ~rst;
    assign flush_if_id_o  = flush_if_id & ~rst;
    assign flush_id_ex_o  = flush_id_ex & ~rst;
    assign flush_ex_mem_o = flush_ex_mem & ~rst;
    assign state_o        = rst ? ST_RUN : state_q;

endmodule
